// File: rtl/simon_pkg.sv
// Shared types for the Simon Says round controller.
//   state_t      : round sequencer states
//   color_t      : 2-bit colour code (0..3)
//   color2onehot : colour code -> one-hot lamp pattern
package simon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        APPEND,
        PLAY_ON,
        PLAY_GAP,
        WAIT_IN,
        ECHO,
        PAUSE,
        LOSE,
        WIN
    } state_t;

    typedef logic [1:0] color_t;

    localparam logic [3:0] LED_ALL = 4'b1111;

    function automatic logic [3:0] color2onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_step_timer.sv
// Single down-counter shared by every timed phase of the sequencer.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with load_val
//   load_val   : dwell length minus one
//   expired    : counter has reached zero (last cycle of the current dwell)
// A dwell of N cycles is obtained by loading N-1 on the entering edge.
module simon_step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/simon_round_sequencer.sv
// Round controller for the Simon Says game core.
// Each round appends one random colour, plays the whole sequence back on the
// lamps/tone, then checks the player's presses step by step.
//   clk, rst_n : clock, async active-low reset
//   start      : new-game pulse, honoured only in IDLE
//   rnd_color  : random colour, sampled in APPEND
//   btn_pulse  : one-hot press pulses from the debouncer
//   led        : one-hot colour lamp, all-on/all-off while flashing a loss/win
//   tone_en    : speaker enable; tone_sel is the colour shown/echoed
//   busy       : any state but IDLE
//   input_ph   : player's turn (WAIT_IN)
//   round_done : pulse, round entered correctly
//   game_lost  : pulse, wrong/multi-bit press or timeout
//   game_won   : pulse, MAX_LEN rounds completed
//   score      : completed rounds, held until the next start
module simon_round_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int ON_CYCLES   = 25_000_000,
    parameter int GAP_CYCLES  = 12_000_000,
    parameter int TIMEOUT_CYC = 150_000_000,
    parameter int PAUSE_CYC   = 50_000_000,
    localparam int SCORE_W    = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         rnd_color,
    input  logic [3:0]         btn_pulse,
    output logic [3:0]         led,
    output logic               tone_en,
    output logic [1:0]         tone_sel,
    output logic               busy,
    output logic               input_ph,
    output logic               round_done,
    output logic               game_lost,
    output logic               game_won,
    output logic [SCORE_W-1:0] score
);

    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W   = SCORE_W;
    localparam int MAX_A   = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int MAX_B   = (TIMEOUT_CYC > PAUSE_CYC) ? TIMEOUT_CYC : PAUSE_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    state_t             state, next_state;
    color_t             mem [MAX_LEN];
    logic [LEN_W-1:0]   len;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         flash;
    logic               flash_step;
    logic               tmr_load, tmr_exp;
    logic [TMR_W-1:0]   tmr_val;

    color_t cur;
    logic   last_step, press, hit, full;

    assign cur       = mem[idx];
    assign last_step = (LEN_W'(idx) == len - LEN_W'(1));
    assign full      = (len == LEN_W'(MAX_LEN));
    // Any press in WAIT_IN is judged; only an exact one-hot match survives,
    // so multi-bit presses fall out as mismatches.
    assign press     = |btn_pulse;
    assign hit       = (btn_pulse == color2onehot(cur));

    simon_step_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        flash_step = 1'b0;
        case (state)
            IDLE:     if (start) next_state = APPEND;
            APPEND:   next_state = PLAY_ON;
            PLAY_ON:  if (tmr_exp) next_state = last_step ? WAIT_IN : PLAY_GAP;
            PLAY_GAP: if (tmr_exp) next_state = PLAY_ON;
            WAIT_IN: begin
                // a press on the expiring cycle still counts as a press
                if (press)
                    next_state = hit ? ECHO : LOSE;
                else if (tmr_exp)
                    next_state = LOSE;
            end
            ECHO: begin
                if (tmr_exp) begin
                    if (!last_step)
                        next_state = WAIT_IN;
                    else
                        next_state = full ? WIN : PAUSE;
                end
            end
            PAUSE:    if (tmr_exp) next_state = APPEND;
            LOSE: begin
                if (tmr_exp) begin
                    if (flash == 2'd3)
                        next_state = IDLE;
                    else
                        flash_step = 1'b1;
                end
            end
            WIN:      if (tmr_exp) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Timer reloads on every state entry; the flash phases of LOSE also
    // reload in-state. A correct press always enters ECHO, so it reloads too.
    always_comb begin
        tmr_load = (next_state != state) || flash_step;
        case (next_state)
            PLAY_ON, ECHO, LOSE: tmr_val = TMR_W'(ON_CYCLES - 1);
            PLAY_GAP:            tmr_val = TMR_W'(GAP_CYCLES - 1);
            WAIT_IN:             tmr_val = TMR_W'(TIMEOUT_CYC - 1);
            PAUSE, WIN:          tmr_val = TMR_W'(PAUSE_CYC - 1);
            default:             tmr_val = '0;
        endcase
    end

    always_comb begin
        led      = '0;
        tone_en  = 1'b0;
        tone_sel = '0;
        case (state)
            // in ECHO the pressed colour equals mem[idx], so reuse it
            PLAY_ON, ECHO: begin
                led      = color2onehot(cur);
                tone_en  = 1'b1;
                tone_sel = cur;
            end
            LOSE:    led = flash[0] ? 4'b0000 : LED_ALL;
            WIN:     led = LED_ALL;
            default: ;
        endcase
    end

    assign busy     = (state != IDLE);
    assign input_ph = (state == WAIT_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= '0;
            idx        <= '0;
            flash      <= '0;
            score      <= '0;
            round_done <= 1'b0;
            game_lost  <= 1'b0;
            game_won   <= 1'b0;
        end else begin
            round_done <= 1'b0;
            game_lost  <= 1'b0;
            game_won   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= '0;
                        idx   <= '0;
                        score <= '0;
                    end
                end
                APPEND: begin
                    len <= len + LEN_W'(1);
                    idx <= '0;
                end
                PLAY_ON:  if (tmr_exp && last_step) idx <= '0;
                PLAY_GAP: if (tmr_exp) idx <= idx + IDX_W'(1);
                ECHO: begin
                    if (tmr_exp) begin
                        if (!last_step) begin
                            idx <= idx + IDX_W'(1);
                        end else begin
                            idx        <= '0;
                            round_done <= 1'b1;
                            game_won   <= full;
                            if (score != SCORE_W'(MAX_LEN))
                                score <= score + SCORE_W'(1);
                        end
                    end
                end
                LOSE:     if (flash_step) flash <= flash + 2'd1;
                default: ;
            endcase
            if (next_state == LOSE && state != LOSE) begin
                game_lost <= 1'b1;
                flash     <= '0;
            end
        end
    end

    // Sequence memory is not reset; entries are always written before read.
    always_ff @(posedge clk) begin
        if (state == APPEND)
            mem[len[IDX_W-1:0]] <= rnd_color;
    end

endmodule

// File: tb/tb_simon_round_sequencer.sv
module tb_simon_round_sequencer;

    localparam int MAX_LEN = 3;
    localparam int ON      = 4;
    localparam int GAP     = 2;
    localparam int TMO     = 20;
    localparam int PAU     = 3;
    localparam int SW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    rnd_color = '0;
    logic [3:0]    btn_pulse = '0;
    logic [3:0]    led;
    logic          tone_en;
    logic [1:0]    tone_sel;
    logic          busy, input_ph, round_done, game_lost, game_won;
    logic [SW-1:0] score;

    simon_round_sequencer #(
        .MAX_LEN(MAX_LEN), .ON_CYCLES(ON), .GAP_CYCLES(GAP),
        .TIMEOUT_CYC(TMO), .PAUSE_CYC(PAU)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rnd_color(rnd_color),
        .btn_pulse(btn_pulse), .led(led), .tone_en(tone_en), .tone_sel(tone_sel),
        .busy(busy), .input_ph(input_ph), .round_done(round_done),
        .game_lost(game_lost), .game_won(game_won), .score(score)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int m_seq[$];     // model of the colour sequence shown this game
    int m_score = 0;  // model of completed rounds

    function automatic logic [3:0] oh(input int c);
        return 4'(1 << c);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        btn_pulse = '0;
        start     = 1'b0;
    endtask

    // junk on every input the current state is supposed to ignore
    task automatic noise();
        btn_pulse = 4'($urandom_range(15, 0));
        start     = 1'($urandom_range(1, 0));
        rnd_color = 2'($urandom_range(3, 0));
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_led, input logic e_ten,
                              input logic [1:0] e_tsel, input logic e_busy, input logic e_inph,
                              input logic e_rd, input logic e_lost, input logic e_won);
        logic [19:0] obs, req;
        obs = {led, tone_en, tone_sel, busy, input_ph, round_done, game_lost, game_won, 8'(score)};
        req = {e_led, e_ten, e_tsel, e_busy, e_inph, e_rd, e_lost, e_won, 8'(m_score)};
        n_chk++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 4'h0, 0, 2'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            expect_out("wait_in", 4'h0, 0, 2'd0, 1, 1, 0, 0, 0);
        end
    endtask

    // From IDLE: pulse start, land in APPEND one clock later.
    task automatic start_game();
        start     = 1'b1;
        btn_pulse = 4'($urandom_range(15, 0));
        tick();
        quiet();
        m_seq.delete();
        m_score = 0;
        expect_out("append", 4'h0, 0, 2'd0, 1, 0, 0, 0, 0);
    endtask

    // In APPEND: supply colour c, check the whole playback, stop in first WAIT_IN cycle.
    task automatic append_and_play(input int c);
        rnd_color = 2'(c);
        m_seq.push_back(c);
        for (int i = 0; i < m_seq.size(); i++) begin
            for (int k = 0; k < ON; k++) begin
                tick();
                expect_out("play_on", oh(m_seq[i]), 1, 2'(m_seq[i]), 1, 0, 0, 0, 0);
                noise();
            end
            if (i < m_seq.size() - 1)
                for (int k = 0; k < GAP; k++) begin
                    tick();
                    expect_out("play_gap", 4'h0, 0, 2'd0, 1, 0, 0, 0, 0);
                    noise();
                end
        end
        tick();
        quiet();
        expect_out("wait_in_entry", 4'h0, 0, 2'd0, 1, 1, 0, 0, 0);
    endtask

    // In LOSE entry cycle: 4 phases of ON clocks, lit/dark/lit/dark, then IDLE.
    task automatic expect_lose();
        expect_out("lose_entry", 4'hF, 0, 2'd0, 1, 0, 0, 1, 0);
        noise();
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < ON; k++) begin
                if (p == 0 && k == 0) continue;
                tick();
                expect_out("lose_flash", (p % 2 == 0) ? 4'hF : 4'h0, 0, 2'd0, 1, 0, 0, 0, 0);
                noise();
            end
        tick();
        quiet();
        expect_idle("idle_after_lose");
    endtask

    // In a WAIT_IN cycle: idle `delay` clocks, then press step j correctly.
    task automatic press_ok(input int j, input int delay);
        wait_cycles(delay);
        btn_pulse = oh(m_seq[j]);
        for (int k = 0; k < ON; k++) begin
            tick();
            expect_out("echo", oh(m_seq[j]), 1, 2'(m_seq[j]), 1, 0, 0, 0, 0);
            noise();
        end
        tick();
        quiet();
        if (j < m_seq.size() - 1) begin
            expect_out("wait_in_next", 4'h0, 0, 2'd0, 1, 1, 0, 0, 0);
        end else begin
            if (m_score < MAX_LEN) m_score++;
            if (m_seq.size() == MAX_LEN) begin
                expect_out("win_entry", 4'hF, 0, 2'd0, 1, 0, 1, 0, 1);
                noise();
                for (int k = 1; k < PAU; k++) begin
                    tick();
                    expect_out("win", 4'hF, 0, 2'd0, 1, 0, 0, 0, 0);
                    noise();
                end
                tick();
                quiet();
                expect_idle("idle_after_win");
            end else begin
                expect_out("pause_entry", 4'h0, 0, 2'd0, 1, 0, 1, 0, 0);
                noise();
                for (int k = 1; k < PAU; k++) begin
                    tick();
                    expect_out("pause", 4'h0, 0, 2'd0, 1, 0, 0, 0, 0);
                    noise();
                end
                tick();
                quiet();
                expect_out("append_next", 4'h0, 0, 2'd0, 1, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic press_bad(input logic [3:0] b, input int delay);
        wait_cycles(delay);
        btn_pulse = b;
        tick();
        expect_lose();
    endtask

    initial begin
        int c;
        #1;
        rst_n     = 1'b0;
        start     = 1'b1;
        btn_pulse = 4'hF;
        repeat (3) begin
            tick();
            expect_idle("reset");
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        expect_idle("idle_after_release");

        // first round colour 2, correct echo, score 1
        start_game();
        append_and_play(2);
        press_ok(0, 0);
        // second round {2,0}: correct then wrong colour -> loss, score held
        append_and_play(0);
        press_ok(0, 3);
        press_bad(4'b0010, 1);
        tick();
        expect_idle("idle_score_held");

        // press on the very last allowed cycle wins; then a full timeout
        start_game();
        append_and_play($urandom_range(3, 0));
        press_ok(0, TMO - 1);
        append_and_play($urandom_range(3, 0));
        wait_cycles(TMO - 1);
        tick();
        expect_lose();

        // multi-bit press
        start_game();
        append_and_play($urandom_range(3, 0));
        press_bad(4'b0011, 0);

        // complete game to MAX_LEN
        start_game();
        for (int r = 0; r < MAX_LEN; r++) begin
            append_and_play($urandom_range(3, 0));
            for (int j = 0; j <= r; j++)
                press_ok(j, $urandom_range(5, 0));
        end

        // async reset in PLAY_GAP of round 2
        start_game();
        append_and_play($urandom_range(3, 0));
        press_ok(0, 1);
        c = $urandom_range(3, 0);
        rnd_color = 2'(c);
        m_seq.push_back(c);
        for (int k = 0; k < ON; k++) begin
            tick();
            expect_out("r2_play_on", oh(m_seq[0]), 1, 2'(m_seq[0]), 1, 0, 0, 0, 0);
        end
        tick();
        expect_out("r2_play_gap", 4'h0, 0, 2'd0, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 m_score = 0;
        expect_idle("async_reset");
        tick();
        expect_idle("reset_hold");
        rst_n = 1'b1;
        tick();
        expect_idle("idle_after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
